// File: rtl/puf_seq_ctrl.sv
// puf_seq_ctrl: host-command sequencer driving the PUF bus interface
// (reset, configure, start, wait for end_op, read back response words into
// a show-ahead FIFO drained over a valid/ready stream).
// Optional feature macro: PUF_SEQ_TIMEOUT_EN adds an end_op watchdog that
// raises the sticky error flag and aborts the sequence through FIN.
module puf_seq_ctrl #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned TIMEOUT_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_bg,
    input  logic             cfg_sd,
    input  logic [1:0]       cfg_cnfa,
    input  logic [12:0]      cfg_n_cmps,
    input  logic [8:0]       cfg_n_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_last,
    output logic [3:0]       itf_control,
    output logic [WIDTH-1:0] itf_address,
    output logic [WIDTH-1:0] itf_data_in,
    input  logic [WIDTH-1:0] itf_data_out,
    input  logic             itf_end_op
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = $clog2(READ_LAT + 1);

    localparam logic [8:0] MAX_WORDS    = 9'd256;
    localparam logic [3:0] CTL_IDLE     = 4'b0000;
    localparam logic [3:0] CTL_RST      = 4'b0011;
    localparam logic [3:0] CTL_LOAD     = 4'b0100;
    localparam logic [3:0] CTL_READ     = 4'b1000;
    localparam logic [3:0] CTL_CORE_RST = 4'b0001;

    // Reject parameter sets the config word layout and FIFO pointers cannot support
    if (WIDTH < 26 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        READ_LAT < 1 || TIMEOUT_W < 1) begin : g_param_check
        $error("puf_seq_ctrl: unsupported parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_CFG, S_GO, S_WAIT, S_ADDR, S_RD, S_PUSH, S_FIN, S_DONE
    } state_t;

    state_t            state;
    logic [8:0]        k;
    logic [8:0]        n_words_q;
    logic              bg_q;
    logic              sd_q;
    logic [1:0]        cnfa_q;
    logic [12:0]       n_cmps_q;
    logic [LAT_W-1:0]  lat_cnt;
`ifdef PUF_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;
`endif

    // FIFO entries carry {last, data}
    logic [WIDTH:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              pop;
    logic              push;
    logic [8:0]        k_inc;
    logic [WIDTH:0]    push_entry;

    // Configuration word: {0, puf_addr, n_cmps, cnfa, sd, bg, puf_str}
    function automatic logic [WIDTH-1:0] cfg_word(input logic str, input logic [7:0] addr);
        logic [WIDTH-1:0] w;
        w = '0;
        w[25:0] = {addr, n_cmps_q, cnfa_q, sd_q, bg_q, str};
        return w;
    endfunction

    // FIFO handshake; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        pop        = rsp_ready && (count != '0);
        push       = (state == S_PUSH) && ((count != CNT_W'(FIFO_DEPTH)) || pop);
        k_inc      = k + 9'd1;
        push_entry = {(k_inc == n_words_q), itf_data_out};
        rd_nxt     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Response FIFO with registered show-ahead head (bypasses a write into an empty head)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            rsp_valid <= (count_nxt != '0);
            if (count_nxt == '0) begin
                {rsp_last, rsp_data} <= '0;
            end else if (push && (wr_ptr == rd_nxt)) begin
                {rsp_last, rsp_data} <= push_entry;
            end else begin
                {rsp_last, rsp_data} <= mem[rd_nxt];
            end
        end
    end

    // Sequencer FSM; interface outputs are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            itf_control <= CTL_IDLE;
            itf_address <= '0;
            itf_data_in <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            k           <= '0;
            n_words_q   <= '0;
            bg_q        <= 1'b0;
            sd_q        <= 1'b0;
            cnfa_q      <= '0;
            n_cmps_q    <= '0;
            lat_cnt     <= '0;
`ifdef PUF_SEQ_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bg_q        <= cfg_bg;
                        sd_q        <= cfg_sd;
                        cnfa_q      <= cfg_cnfa;
                        n_cmps_q    <= cfg_n_cmps;
                        n_words_q   <= (cfg_n_words > MAX_WORDS) ? MAX_WORDS : cfg_n_words;
                        busy        <= 1'b1;
                        error       <= 1'b0;
                        itf_control <= CTL_RST;
                        itf_address <= '0;
                        state       <= S_RST;
                    end
                end
                S_RST: begin
                    itf_control <= CTL_LOAD;
                    itf_address <= '0;
                    itf_data_in <= cfg_word(1'b0, 8'd0);
                    state       <= S_CFG;
                end
                S_CFG: begin
                    itf_data_in <= cfg_word(1'b1, 8'd0);
                    state       <= S_GO;
                end
                S_GO: begin
                    itf_control <= CTL_IDLE;
                    k           <= '0;
`ifdef PUF_SEQ_TIMEOUT_EN
                    to_cnt      <= '0;
`endif
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (itf_end_op) begin
                        if (n_words_q == '0) begin
                            itf_control <= CTL_CORE_RST;
                            state       <= S_FIN;
                        end else begin
                            itf_control <= CTL_LOAD;
                            itf_data_in <= cfg_word(1'b1, 8'd0);
                            state       <= S_ADDR;
                        end
                    end
`ifdef PUF_SEQ_TIMEOUT_EN
                    else if (to_cnt == '1) begin
                        error       <= 1'b1;
                        itf_control <= CTL_CORE_RST;
                        state       <= S_FIN;
                    end else begin
                        to_cnt <= to_cnt + TIMEOUT_W'(1);
                    end
`endif
                end
                S_ADDR: begin
                    itf_control <= CTL_READ;
                    itf_address <= WIDTH'(1);
                    lat_cnt     <= '0;
                    state       <= S_RD;
                end
                S_RD: begin
                    if (lat_cnt == LAT_W'(READ_LAT - 1)) begin
                        itf_control <= CTL_IDLE;
                        state       <= S_PUSH;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_PUSH: begin
                    if (push) begin
                        k           <= k_inc;
                        itf_address <= '0;
                        if (k_inc < n_words_q) begin
                            itf_control <= CTL_LOAD;
                            itf_data_in <= cfg_word(1'b1, k_inc[7:0]);
                            state       <= S_ADDR;
                        end else begin
                            itf_control <= CTL_CORE_RST;
                            state       <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    itf_control <= CTL_IDLE;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    itf_control <= CTL_IDLE;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_seq_ctrl.sv
// Directed testbench for puf_seq_ctrl with a behavioural PUF interface stub.
// Compile with PUF_SEQ_TIMEOUT_EN defined to include the watchdog scenario.
module tb_puf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cfg_bg;
    logic        cfg_sd;
    logic [1:0]  cfg_cnfa;
    logic [12:0] cfg_n_cmps;
    logic [8:0]  cfg_n_words;
    logic        busy;
    logic        done;
    logic        error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_last;
    logic [3:0]  itf_control;
    logic [63:0] itf_address;
    logic [63:0] itf_data_in;
    logic [63:0] itf_data_out = '0;
    logic        itf_end_op = 1'b0;

    int errors = 0;
    int checks = 0;

    // Stub state
    logic [63:0] stub_word = '0;
    int          wait_cnt = 0;
    int          endop_delay = 1000000;

    // Logs
    logic [64:0] got_q[$];
    logic [63:0] ld_q[$];
    int          fin_cnt = 0;
    int          done_cnt = 0;

    puf_seq_ctrl #(
        .WIDTH(64), .FIFO_DEPTH(4), .READ_LAT(1), .TIMEOUT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_bg(cfg_bg), .cfg_sd(cfg_sd), .cfg_cnfa(cfg_cnfa),
        .cfg_n_cmps(cfg_n_cmps), .cfg_n_words(cfg_n_words),
        .busy(busy), .done(done), .error(error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .itf_control(itf_control), .itf_address(itf_address),
        .itf_data_in(itf_data_in), .itf_data_out(itf_data_out),
        .itf_end_op(itf_end_op)
    );

    always #5 clk = ~clk;

    // PUF interface stub: latches loads, raises end_op endop_delay cycles after str, returns BEEF|puf_addr
    always @(posedge clk) begin
        if (rst || itf_control[0]) begin
            stub_word  <= '0;
            wait_cnt   <= 0;
            itf_end_op <= 1'b0;
        end else begin
            if (itf_control[2] && itf_address == 64'd0) stub_word <= itf_data_in;
            if (stub_word[0] && !itf_end_op) begin
                if (wait_cnt >= endop_delay) itf_end_op <= 1'b1;
                else wait_cnt <= wait_cnt + 1;
            end
        end
        if (itf_control[3]) itf_data_out <= {16'hBEEF, 40'h0, stub_word[25:18]};
    end

    // Monitor: popped words, load words, FIN cycles, done pulses
    always @(posedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_last, rsp_data});
            if (itf_control == 4'b0100) ld_q.push_back(itf_data_in);
            if (itf_control == 4'b0001) fin_cnt++;
            if (done) done_cnt++;
        end
    end

    function automatic logic [64:0] exp_rsp(input int k, input bit last);
        return {last, 16'hBEEF, 40'h0, 8'(k)};
    endfunction

    task automatic clear_logs();
        got_q.delete();
        ld_q.delete();
        fin_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic start_seq(input bit bg, input bit sd, input logic [1:0] cnfa,
                             input logic [12:0] ncmps, input logic [8:0] nwords);
        cfg_bg = bg; cfg_sd = sd; cfg_cnfa = cnfa; cfg_n_cmps = ncmps; cfg_n_words = nwords;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (itf_control !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", itf_control); end
        checks++; if (itf_address !== 64'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", itf_address); end
        checks++; if (itf_data_in !== 64'd0) begin errors++; $display("FAIL reset_din: got %h want 0", itf_data_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", rsp_last); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        logic [63:0] exp_ld [6];
        bit ok;
        exp_ld[0] = 64'h0C96; exp_ld[1] = 64'h0C97; exp_ld[2] = 64'h0C97;
        exp_ld[3] = 64'h40C97; exp_ld[4] = 64'h80C97; exp_ld[5] = 64'hC0C97;
        clear_logs();
        endop_delay = 50;
        rsp_ready = 1'b1;
        start_seq(1'b1, 1'b1, 2'd2, 13'd100, 9'd4);
        checks++; if (itf_control !== 4'b0011) begin errors++; $display("FAIL nom_rst_ctl: got %b want 0011", itf_control); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (itf_control !== 4'b0100) begin errors++; $display("FAIL nom_cfg_ctl: got %b want 0100", itf_control); end
        checks++; if (itf_data_in !== 64'h0C96) begin errors++; $display("FAIL nom_cfg_word: got %h want 0c96", itf_data_in); end
        @(negedge clk);
        checks++; if (itf_data_in !== 64'h0C97) begin errors++; $display("FAIL nom_go_word: got %h want 0c97", itf_data_in); end
        @(negedge clk);
        checks++; if (itf_control !== 4'b0000) begin errors++; $display("FAIL nom_wait_ctl: got %b want 0000", itf_control); end
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nom_done_timeout: got no done want done within 400 cycles"); end
        repeat (2) @(negedge clk);
        checks++; if (ld_q.size() != 6) begin errors++; $display("FAIL nom_ld_count: got %0d want 6", ld_q.size()); end
        if (ld_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (ld_q[i] !== exp_ld[i]) begin errors++; $display("FAIL nom_ld[%0d]: got %h want %h", i, ld_q[i], exp_ld[i]); end
            end
        end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL nom_rsp_count: got %0d want 4", got_q.size()); end
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[i] !== exp_rsp(i, i == 3)) begin errors++; $display("FAIL nom_rsp[%0d]: got %h want %h", i, got_q[i], exp_rsp(i, i == 3)); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL nom_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (fin_cnt != 1) begin errors++; $display("FAIL nom_fin_cycles: got %0d want 1", fin_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_end: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL nom_error: got %b want 0", error); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        endop_delay = 5;
        rsp_ready = 1'b0;
        start_seq(1'b1, 1'b1, 2'd2, 13'd100, 9'd8);
        repeat (80) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy_stall: got %b want 1", busy); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stall: got %b want 1", rsp_valid); end
        checks++; if ({rsp_last, rsp_data} !== exp_rsp(0, 1'b0)) begin errors++; $display("FAIL bp_head: got %h want %h", {rsp_last, rsp_data}, exp_rsp(0, 1'b0)); end
        checks++; if (ld_q.size() != 7) begin errors++; $display("FAIL bp_ld_stall: got %0d want 7", ld_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL bp_no_done: got %0d want 0", done_cnt); end
        rsp_ready = 1'b1;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: got no done want done within 200 cycles"); end
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL bp_rsp_count: got %0d want 8", got_q.size()); end
        if (got_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_q[i] !== exp_rsp(i, i == 7)) begin errors++; $display("FAIL bp_rsp[%0d]: got %h want %h", i, got_q[i], exp_rsp(i, i == 7)); end
            end
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_zero_words();
        bit ok;
        clear_logs();
        endop_delay = 3;
        rsp_ready = 1'b1;
        start_seq(1'b0, 1'b0, 2'd0, 13'd1, 9'd0);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout: got no done want done within 100 cycles"); end
        repeat (2) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_rsp_count: got %0d want 0", got_q.size()); end
        checks++; if (ld_q.size() != 2) begin errors++; $display("FAIL zero_ld_count: got %0d want 2", ld_q.size()); end
        checks++; if (fin_cnt != 1) begin errors++; $display("FAIL zero_fin: got %0d want 1", fin_cnt); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_clamp();
        bit ok;
        int bad;
        clear_logs();
        endop_delay = 2;
        rsp_ready = 1'b1;
        start_seq(1'b1, 1'b1, 2'd2, 13'd100, 9'd300);
        wait_done(1500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_done_timeout: got no done want done within 1500 cycles"); end
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 256) begin errors++; $display("FAIL clamp_rsp_count: got %0d want 256", got_q.size()); end
        checks++; if (ld_q.size() != 258) begin errors++; $display("FAIL clamp_ld_count: got %0d want 258", ld_q.size()); end
        if (ld_q.size() == 258) begin
            checks++; if (ld_q[257] !== 64'h3FC0C97) begin errors++; $display("FAIL clamp_last_addr: got %h want 3fc0c97", ld_q[257]); end
        end
        if (got_q.size() == 256) begin
            bad = 0;
            for (int i = 0; i < 256; i++) if (got_q[i] !== exp_rsp(i, i == 255)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL clamp_rsp_order: got %0d bad words want 0", bad); end
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        clear_logs();
        endop_delay = 30;
        rsp_ready = 1'b1;
        start_seq(1'b0, 1'b1, 2'd1, 13'd7, 9'd2);
        repeat (8) @(negedge clk);
        start_seq(1'b1, 1'b0, 2'd3, 13'd8191, 9'd5);
        checks++; if (itf_control !== 4'b0000) begin errors++; $display("FAIL swb_ctl: got %b want 0000", itf_control); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL swb_done_timeout: got no done want done within 200 cycles"); end
        repeat (2) @(negedge clk);
        checks++; if (ld_q.size() != 4) begin errors++; $display("FAIL swb_ld_count: got %0d want 4", ld_q.size()); end
        if (ld_q.size() == 4) begin
            checks++; if (ld_q[0] !== 64'hEC) begin errors++; $display("FAIL swb_cfg_word: got %h want ec", ld_q[0]); end
            checks++; if (ld_q[3] !== 64'h400ED) begin errors++; $display("FAIL swb_addr1_word: got %h want 400ed", ld_q[3]); end
        end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL swb_rsp_count: got %0d want 2", got_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL swb_done_pulses: got %0d want 1", done_cnt); end
    endtask

`ifdef PUF_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit seen;
        clear_logs();
        endop_delay = 1000000;
        rsp_ready = 1'b1;
        start_seq(1'b1, 1'b1, 2'd2, 13'd100, 9'd4);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (error) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_error: got 0 want 1 within 60 cycles"); end
        checks++; if (itf_control !== 4'b0001) begin errors++; $display("FAIL to_fin_ctl: got %b want 0001", itf_control); end
        wait_done(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_done_timeout: got no done want done within 10 cycles"); end
        checks++; if (ld_q.size() != 2) begin errors++; $display("FAIL to_no_readout: got %0d loads want 2", ld_q.size()); end
        @(negedge clk);
        endop_delay = 3;
        start_seq(1'b0, 1'b0, 2'd0, 13'd1, 9'd0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_error_clear: got %b want 0", error); end
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_done2_timeout: got no done want done within 100 cycles"); end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        bit seen;
        clear_logs();
        endop_delay = 3;
        rsp_ready = 1'b0;
        start_seq(1'b1, 1'b1, 2'd2, 13'd100, 9'd4);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (itf_control == 4'b1000 && ld_q.size() == 5) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_reach_rd2: got no RD of word 2 want RD within 200 cycles"); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (itf_control !== 4'b0000) begin errors++; $display("FAIL rmid_ctl: got %b want 0000", itf_control); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_flushed: got %b want 0", rsp_valid); end
        checks++; if (fin_cnt != 0) begin errors++; $display("FAIL rmid_no_fin: got %0d want 0", fin_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_bg = 1'b0; cfg_sd = 1'b0; cfg_cnfa = '0; cfg_n_cmps = '0; cfg_n_words = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_zero_words();
        test_clamp();
        test_start_while_busy();
`ifdef PUF_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
